// File: rtl/count_pkg.sv
// Shared definitions for the minutes/seconds timekeeping stage.
package count_pkg;

  typedef enum logic {
    S_COUNT = 1'b0,
    S_CHECK = 1'b1
  } state_t;

  localparam logic [7:0] BCD_ZERO  = 8'h00;
  localparam logic [7:0] BCD_MAX60 = 8'h59;

  // True when the byte is a legal 00-59 BCD value.
  function automatic logic bcd60_valid(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter running 00..59 with a synchronous load.
module bcd_mod60
  import count_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] next_val;

  // The wrap flag tells the next stage that this increment rolls 59 over to 00.
  assign wrap = inc && (value == BCD_MAX60);

  // Next BCD value: bump units, carry into tens, wrap at 59.
  always_comb begin
    next_val = value;
    if (value[3:0] == 4'd9) begin
      if (value[7:4] >= 4'd5) next_val = BCD_ZERO;
      else                    next_val = {value[7:4] + 4'd1, 4'd0};
    end else begin
      next_val = {value[7:4], value[3:0] + 4'd1};
    end
  end

  // A load takes priority; the top level never loads and increments together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    value <= BCD_ZERO;
    else if (load) value <= load_val;
    else if (inc)  value <= next_val;
  end

endmodule

// File: rtl/count_min_sec.sv
// Minutes/seconds BCD timekeeper with prescaler, set handshake and hour carry.
module count_min_sec
  import count_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set_valid,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic       set_ready,
  output logic       set_done,
  output logic       set_err,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       sec_tick,
  output logic       count_carry
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic [7:0]    shadow_min;
  logic [7:0]    shadow_sec;
  logic          counting;
  logic          tick;
  logic          accept;
  logic          shadow_ok;
  logic          load_now;
  logic          sec_wrap;
  logic          min_wrap;

  assign counting  = (state == S_COUNT) && run;
  assign tick      = counting && (presc == PRESC_LAST);
  assign accept    = set_valid && set_ready;
  assign shadow_ok = bcd60_valid(shadow_min) && bcd60_valid(shadow_sec);
  assign load_now  = (state == S_CHECK) && shadow_ok;

  // Prescaler: restarts on a valid load, otherwise free-runs while counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        presc <= '0;
    else if (load_now) presc <= '0;
    else if (counting) presc <= tick ? '0 : presc + 1'b1;
  end

  // Set handshake FSM: capture on accept, validate for one cycle, report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_COUNT;
      set_ready  <= 1'b1;
      set_done   <= 1'b0;
      set_err    <= 1'b0;
      shadow_min <= BCD_ZERO;
      shadow_sec <= BCD_ZERO;
    end else begin
      set_done <= 1'b0;
      set_err  <= 1'b0;
      case (state)
        S_COUNT: begin
          if (accept) begin
            shadow_min <= set_min;
            shadow_sec <= set_sec;
            state      <= S_CHECK;
            set_ready  <= 1'b0;
          end
        end
        S_CHECK: begin
          set_done  <= shadow_ok;
          set_err   <= ~shadow_ok;
          state     <= S_COUNT;
          set_ready <= 1'b1;
        end
        default: begin
          state     <= S_COUNT;
          set_ready <= 1'b1;
        end
      endcase
    end
  end

  // Advance pulses line up with the new time appearing on minute/second.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_tick    <= 1'b0;
      count_carry <= 1'b0;
    end else begin
      sec_tick    <= tick;
      count_carry <= min_wrap;
    end
  end

  bcd_mod60 u_seconds (
    .clk      (clk),
    .reset    (reset),
    .inc      (tick),
    .load     (load_now),
    .load_val (shadow_sec),
    .value    (second),
    .wrap     (sec_wrap)
  );

  bcd_mod60 u_minutes (
    .clk      (clk),
    .reset    (reset),
    .inc      (sec_wrap),
    .load     (load_now),
    .load_val (shadow_min),
    .value    (minute),
    .wrap     (min_wrap)
  );

endmodule

// File: tb/tb_count_min_sec.sv
// Scoreboard bench for count_min_sec against an elapsed-seconds reference model.
module tb_count_min_sec;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       set_valid;
  logic [7:0] set_min;
  logic [7:0] set_sec;
  logic       set_ready;
  logic       set_done;
  logic       set_err;
  logic [7:0] minute;
  logic [7:0] second;
  logic       sec_tick;
  logic       count_carry;

  count_min_sec #(.TICK_DIV(TICK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .set_valid   (set_valid),
    .set_min     (set_min),
    .set_sec     (set_sec),
    .set_ready   (set_ready),
    .set_done    (set_done),
    .set_err     (set_err),
    .minute      (minute),
    .second      (second),
    .sec_tick    (sec_tick),
    .count_carry (count_carry)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       done;
    logic       err;
    logic       tick;
    logic       carry;
    logic [7:0] mm;
    logic [7:0] ss;
  } ev_t;

  ev_t exp_q[$];

  int total = 0;
  int bad = 0;
  int tick_count = 0;
  int carry_count = 0;
  int done_count = 0;

  // Reference model: elapsed seconds in the hour plus a cycle counter.
  int         m_t;
  int         m_presc;
  bit         m_pend;
  logic [7:0] m_sm;
  logic [7:0] m_ss;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    m_presc = 0;
    m_pend = 0;
    m_sm = 8'h00;
    m_ss = 8'h00;
  endtask

  // Predict what the next clock edge does with the inputs now being driven.
  task automatic model_step();
    ev_t e;
    bit  fire;
    e = '0;
    fire = 0;
    if (!m_pend) begin
      if (run) begin
        if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          m_t = (m_t + 1) % 3600;
          e.tick = 1'b1;
          e.carry = (m_t == 0);
          fire = 1;
        end else begin
          m_presc++;
        end
      end
      if (set_valid) begin
        m_pend = 1;
        m_sm = set_min;
        m_ss = set_sec;
      end
    end else begin
      m_pend = 0;
      if (digits_ok(m_sm) && digits_ok(m_ss)) begin
        m_t = from_bcd(m_sm) * 60 + from_bcd(m_ss);
        m_presc = 0;
        e.done = 1'b1;
      end else begin
        e.err = 1'b1;
      end
      fire = 1;
    end
    if (fire) begin
      e.mm = to_bcd(m_t / 60);
      e.ss = to_bcd(m_t % 60);
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_time(input logic [7:0] mm, input logic [7:0] ss, input bit good);
    set_valid = 1'b1;
    set_min = mm;
    set_sec = ss;
    cycle();
    set_valid = 1'b0;
    chk("ready_low_in_check", int'(set_ready), 0);
    cycle();
    chk("ready_back", int'(set_ready), 1);
    if (good) begin
      chk("set_minute", int'(minute), int'(mm));
      chk("set_second", int'(second), int'(ss));
    end else begin
      chk("keep_minute", int'(minute), int'(to_bcd(m_t / 60)));
      chk("keep_second", int'(second), int'(to_bcd(m_t % 60)));
    end
  endtask

  // Monitor: whenever the DUT shows an event, pop and compare its prediction.
  always @(negedge clk) begin : monitor
    ev_t got;
    ev_t want;
    if (reset) begin
      if (sec_tick) tick_count++;
      if (count_carry) carry_count++;
      if (set_done) done_count++;
      if (sec_tick || count_carry || set_done || set_err) begin
        got = {set_done, set_err, sec_tick, count_carry, minute, second};
        if (exp_q.size() == 0) begin
          chk("unexpected_event", int'(got), 0);
        end else begin
          want = exp_q.pop_front();
          chk("event", int'(got), int'(want));
        end
      end
    end
  end

  initial begin
    int         saved_ticks;
    int         saved_done;
    logic [7:0] frz_m;
    logic [7:0] frz_s;
    bit         acc;

    reset = 1'b0;
    run = 1'b0;
    set_valid = 1'b0;
    set_min = 8'h00;
    set_sec = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_minute", int'(minute), 0);
    chk("rst_second", int'(second), 0);
    chk("rst_ready", int'(set_ready), 1);
    chk("rst_done", int'(set_done), 0);
    chk("rst_err", int'(set_err), 0);
    chk("rst_tick", int'(sec_tick), 0);
    chk("rst_carry", int'(count_carry), 0);

    reset = 1'b1;
    run = 1'b1;
    repeat (41) cycle();
    chk("run40_second", int'(second), 8'h10);
    chk("run40_minute", int'(minute), 8'h00);
    chk("run40_ticks", tick_count, 10);
    chk("run40_carries", carry_count, 0);

    set_time(8'h59, 8'h58, 1'b1);
    repeat (9) cycle();
    chk("rollover_carries", carry_count, 1);
    chk("rollover_minute", int'(minute), 8'h00);
    chk("rollover_second", int'(second), 8'h00);

    set_time(8'h12, 8'h34, 1'b1);
    set_time(8'h6A, 8'h30, 1'b0);
    set_time(8'h25, 8'h60, 1'b0);
    set_time(8'h00, 8'h00, 1'b1);

    repeat (2) cycle();
    run = 1'b0;
    frz_m = to_bcd(m_t / 60);
    frz_s = to_bcd(m_t % 60);
    saved_ticks = tick_count;
    repeat (100) cycle();
    chk("frozen_minute", int'(minute), int'(frz_m));
    chk("frozen_second", int'(second), int'(frz_s));
    chk("frozen_ticks", tick_count - saved_ticks, 0);
    run = 1'b1;
    repeat (10) cycle();

    for (int i = 0; i < 1500; i++) begin
      if (!set_valid && ($urandom_range(0, 9) == 0)) begin
        set_valid = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          set_min = to_bcd(int'($urandom_range(0, 59)));
          set_sec = to_bcd(int'($urandom_range(0, 59)));
        end else begin
          set_min = 8'($urandom);
          set_sec = 8'($urandom);
        end
      end
      run = ($urandom_range(0, 9) != 0);
      acc = set_valid && !m_pend;
      cycle();
      if (acc) set_valid = 1'b0;
    end

    set_valid = 1'b0;
    run = 1'b1;
    repeat (3) cycle();

    set_valid = 1'b1;
    set_min = 8'h12;
    set_sec = 8'h34;
    cycle();
    #1;
    reset = 1'b0;
    set_valid = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk("async_minute", int'(minute), 0);
    chk("async_second", int'(second), 0);
    chk("async_ready", int'(set_ready), 1);
    chk("async_done", int'(set_done), 0);
    chk("async_tick", int'(sec_tick), 0);
    saved_done = done_count;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    run = 1'b1;
    repeat (21) cycle();
    chk("post_reset_done", done_count - saved_done, 0);
    chk("post_reset_second", int'(second), 8'h05);
    chk("post_reset_minute", int'(minute), 8'h00);

    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_min_sec.md
Name: count_min_sec

Overview:
Minutes/seconds BCD timekeeping stage that sits directly upstream of the hour counter. A prescaler divides the system clock down to a 1-per-second tick. The tick drives a BCD seconds counter (00-59) that feeds a BCD minutes counter (00-59). On the 59:59 -> 00:00 rollover the block emits a one-cycle count_carry pulse that is the hour stage's advance. A valid/ready set port loads a validated mm:ss value.

Parameters:
TICK_DIV, 50000000, clk cycles per second tick; legal range >= 1; prescaler width is ceil(log2(TICK_DIV)), minimum 1.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-low; clears all state.
run  input  1  count enable; 0 freezes the prescaler and the time.
set_valid  input  1  set request; held until accepted.
set_min  input  8  BCD minutes to load, [7:4] tens, [3:0] units.
set_sec  input  8  BCD seconds to load, same format.
set_ready  output  1  block can accept a set request this cycle.
set_done  output  1  one-cycle pulse: set value loaded.
set_err  output  1  one-cycle pulse: set value rejected (non-BCD or >59).
minute  output  8  BCD minutes, registered.
second  output  8  BCD seconds, registered.
sec_tick  output  1  one-cycle pulse on every second advance.
count_carry  output  1  one-cycle pulse on the 59:59 -> 00:00 rollover, to the hour stage.

Behaviour:
- Reset (reset=0, asynchronous):
  - minute=8'h00, second=8'h00, prescaler=0, state=S_COUNT.
  - set_ready=1; set_done, set_err, sec_tick and count_carry all 0.
  - Reset asserted mid-operation aborts any pending set; nothing loads afterwards.
- FSM, two states:
  - S_COUNT: counting active; set_ready=1.
  - S_CHECK: one cycle only; set_ready=0; prescaler and time held.
- Prescaler, in S_COUNT with run=1:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - The wrap cycle generates the internal tick.
  - TICK_DIV=1 gives a tick on every enabled cycle.
- Second advance on tick:
  - Seconds units 0-8: units+1.
  - Units 9, tens <5: units=0, tens+1.
  - Seconds 59: second=00 and minutes advance by the same units/tens rule.
  - Minutes 59 with seconds 59: result 00:00 and count_carry=1.
- Output timing:
  - sec_tick and count_carry are registered and assert in the same cycle the new time appears on minute/second.
  - Both deassert the next cycle.
- run=0: prescaler frozen at its current value; no ticks; time unchanged; set path still operates.
- Set handshake:
  - Transfer occurs when set_valid=1 in a cycle where set_ready=1.
  - In that cycle set_min and set_sec are captured into shadow registers and the state moves to S_CHECK.
  - A tick landing on the accept cycle is still applied, so time and count_carry update normally that cycle.
- In S_CHECK, validity test: each units digit <=9 and each tens digit <=5.
  - Valid: minute/second load the shadow values, prescaler clears to 0, set_done=1 next cycle.
  - Invalid: time unchanged, prescaler unchanged, set_err=1 next cycle.
  - Either way, return to S_COUNT.
- Back-to-back sets: set_ready returns to 1 in the cycle after S_CHECK, so a held set_valid is accepted again one cycle later. Maximum throughput is one set per 2 cycles.
- A load never generates count_carry or sec_tick, including a load of 00:00.
- Illegal internal states cannot arise from the set path: the validity check guarantees minute/second always hold 00-59 BCD.

Decomposition:
- Shared package count_pkg:
  - state encoding S_COUNT/S_CHECK.
  - BCD_ZERO (8'h00) and BCD_MAX60 (8'h59) constants.
  - function bcd60_valid(8-bit) returning 1 for legal 00-59 BCD.
- One natural sub-module, bcd_mod60: 8-bit BCD 00-59 counter with inc, load, load_val, and a wrap output.
  - Instanced twice: seconds, and minutes enabled by the seconds wrap.
  - Top level holds the prescaler, FSM, handshake and output pulse registers.

Test Plan:
- Reset release, TICK_DIV=4, run=1 for 40 cycles -> second=8'h10, minute=8'h00, exactly 10 sec_tick pulses, no count_carry.
- Set 59:58, run 8 cycles (TICK_DIV=4) -> 59:59, then 00:00 with count_carry=1 for exactly one cycle, coincident with sec_tick.
- set_valid with set_min=8'h12, set_sec=8'h34 -> set_ready low one cycle, set_done pulse, minute=8'h12, second=8'h34, prescaler=0.
- Set 8'h6A / 8'h30 -> set_err pulse, minute/second unchanged, no set_done.
- run=0 for 100 cycles mid-count -> outputs and prescaler frozen; run=1 resumes from the frozen prescaler value.
- Assert reset asynchronously (not on a clk edge) while in S_CHECK -> all outputs reset immediately; no set_done after release.
